sync_debouncer: RTL
===================

Name: sync_debouncer

Overview:
Parametrised input conditioner for asynchronous keypad column lines (and other slow mechanical inputs). Each bit passes through a SYNC_STAGES-deep flop synchronizer, then an independent debounce filter. The filter accepts a level change only after it persists for DEBOUNCE_CYCLES consecutive clocks. The block also emits one-cycle rise/fall pulses per bit, and sits between the column pins and the keypad scanner FSM.

Parameters:
WIDTH, 4, number of independent input bits
SYNC_STAGES, 2, synchronizer flop depth per bit; legal range >= 2
DEBOUNCE_CYCLES, 16, consecutive clocks a new level must persist before acceptance; legal range >= 1
RESET_LEVEL, 1'b0, idle level loaded into every sync flop and every stable bit on reset

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-low reset
cols  input  WIDTH  raw asynchronous inputs
synchronized_cols  output  WIDTH  last synchronizer stage; no filtering applied
stable_cols  output  WIDTH  debounced level
rise  output  WIDTH  one-cycle pulse on an accepted 0->1 transition of stable_cols[i]
fall  output  WIDTH  one-cycle pulse on an accepted 1->0 transition of stable_cols[i]
any_change  output  1  OR-reduction of (rise | fall)

Behaviour:
- Reset (reset == 0, asynchronous): all sync flops and stable_cols = {WIDTH{RESET_LEVEL}}; all counters = 0; rise = fall = 0; any_change = 0.
- Reset deassertion: no pulse is generated, even if cols differs from RESET_LEVEL. The difference is debounced normally.
- Synchronizer: synchronized_cols reflects cols after SYNC_STAGES rising edges.
- Debounce, per bit i, evaluated every rising edge, with D = DEBOUNCE_CYCLES and CW = $clog2(D+1):
  - synchronized_cols[i] == stable_cols[i]: cnt[i] <= 0; no change.
  - Bits differ and cnt[i] < D-1: cnt[i] <= cnt[i] + 1.
  - Bits differ and cnt[i] == D-1: stable_cols[i] <= synchronized_cols[i]; cnt[i] <= 0; the matching rise[i] or fall[i] <= 1.
  - Every other cycle: rise[i] = fall[i] = 0.
- Latency: stable_cols[i] changes D edges after synchronized_cols[i] changes, so SYNC_STAGES + D edges after a clean cols step.
- rise/fall are registered and assert in the same cycle stable_cols first shows the new value.
- D == 1 degenerates to a single register stage: accept on the next edge.
- Glitch rejection: any excursion shorter than D cycles at synchronized_cols resets cnt[i] to 0, and stable_cols[i] never moves. A bounce restarts the count from 0.
- Counters never wrap. The maximum value held is D-1.
- Bits are fully independent. Simultaneous acceptances on several bits in one cycle assert several rise/fall bits together. any_change is high for that single cycle.
- A change reverting exactly on the acceptance edge is still accepted, because the decision uses the pre-edge synchronized value. The reverse transition then needs a full D cycles.
- Reset asserted mid-count: counters clear immediately and no pulse is emitted.
- All outputs come directly from flops, except any_change, which is a combinational OR of registered pulses.

Decomposition:
- keypad_pkg holds the shared constants: default WIDTH (4), default SYNC_STAGES (2), default DEBOUNCE_CYCLES, and the column idle level.
- One natural sub-module, debounce_bit: one bit's counter, stable flop and rise/fall flops, parametrised by DEBOUNCE_CYCLES and RESET_LEVEL.
- The top level holds the synchronizer shift registers, instantiates WIDTH copies of debounce_bit via a generate loop, and computes any_change.

Test Plan:
Bench overrides for every scenario: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
1. Reset held low with cols=4'b1111 -> all outputs 0. Release reset and hold cols -> synchronized_cols=1111 after 2 edges, stable_cols=1111 after 6 edges, rise=1111 for exactly that one cycle, any_change=1 once.
2. Clean step: cols 0000->0100 -> synchronized_cols[2]=1 at edge 2, stable_cols[2]=1 and rise=0100 at edge 6. Later step cols->0000 -> fall=0100 at edge 6 after the step.
3. Bounce: cols[0] toggles 1,0,1,0 with 1-cycle periods, then holds 1 -> no pulse during bouncing; stable_cols[0]=1 exactly 4 edges after the last synchronized transition.
4. Glitch: cols[3]=1 for 3 cycles, then 0 -> stable_cols remains 0000 and rise/fall/any_change never assert.
5. Simultaneous edges: cols 0011->1100 in one step -> on the same cycle, rise=1100, fall=0011, any_change=1 for one cycle, stable_cols=1100.
6. Reset mid-count: cols=0001 held 2 cycles after sync, then reset pulsed low -> stable_cols=0000 and pulses=0 immediately (asynchronously). After release, stable_cols[0]=1 exactly 6 edges later, with a single rise pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad column input path.
package keypad_pkg;

  localparam int unsigned KP_WIDTH           = 4;
  localparam int unsigned KP_SYNC_STAGES     = 2;
  localparam int unsigned KP_DEBOUNCE_CYCLES = 16;
  localparam logic        KP_COL_IDLE_LEVEL  = 1'b0;

  // Counter width able to hold the values 0..d
  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One column bit's debounce filter: persistence counter, accepted level and
// registered one-cycle rise/fall pulses.
module debounce_bit
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = KP_COL_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LP_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;
  logic          r_rise;
  logic          r_fall;
  logic          w_differ;
  logic          w_accept;

  // The decision uses the pre-edge synchronized value, so a level that
  // reverts exactly on the acceptance edge is still taken.
  assign w_differ = i_sync ^ r_stable;
  assign w_accept = w_differ && (r_cnt == LP_LAST);

  // Count consecutive disagreeing cycles; accept on the last one, restart on any agreement.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= RESET_LEVEL;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= w_accept & i_sync;
      r_fall <= w_accept & ~i_sync;
      if (!w_differ || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_stable <= i_sync;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

endmodule

// File: rtl/sync_debouncer.sv
// Column input conditioner: per-bit flop synchronizer followed by an
// independent debounce filter with accepted-edge pulses.
module sync_debouncer
  import keypad_pkg::*;
#(
  parameter int unsigned WIDTH           = KP_WIDTH,
  parameter int unsigned SYNC_STAGES     = KP_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = KP_DEBOUNCE_CYCLES,
  parameter logic        RESET_LEVEL     = KP_COL_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cols,
  output logic [WIDTH-1:0] synchronized_cols,
  output logic [WIDTH-1:0] stable_cols,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_stable;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;

  // Synchronizer chain: stage 0 samples the raw pins, the last stage feeds the filters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {(SYNC_STAGES * WIDTH){RESET_LEVEL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], cols};
    end
  end

  assign synchronized_cols = r_sync[SYNC_STAGES-1];

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_debounce_bit (
      .clk      (clk),
      .reset    (reset),
      .i_sync   (r_sync[SYNC_STAGES-1][g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g]),
      .o_fall   (w_fall[g])
    );
  end

  assign stable_cols = w_stable;
  assign rise        = w_rise;
  assign fall        = w_fall;
  assign any_change  = |(w_rise | w_fall);

endmodule
